rx_sr_param: RTL and testbench
==============================

RX_SR_PARAM -- requirements
Module: rx_sr_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per received word; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = first received bit lands in rx_word[DATA_WIDTH-1], 0 = first bit lands in rx_word[0].
REQ-003 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port sda_in  input  1  serial data line, already synchronised.
REQ-006 Port rising_edge_found  input  1  single-cycle pulse marking an SCL rising edge.
REQ-007 Port rx_enable  input  1  qualifies sampling; strobes while low are ignored.
REQ-008 Port rx_clear  input  1  synchronous abort; discards any partial word.
REQ-009 Port rx_data  output  DATA_WIDTH  live shift-register contents.
REQ-010 Port rx_word  output  DATA_WIDTH  completed word, held stable while rx_valid=1.
REQ-011 Port rx_valid  output  1  completed word is available.
REQ-012 Port rx_ack  input  1  consumer accepts rx_word.
REQ-013 Port bit_count  output  $clog2(DATA_WIDTH+2)  bits received in the current frame.
REQ-014 Port overrun  output  1  sticky flag: a word completed while rx_valid=1.
REQ-015 Port parity_err  output  1  parity failure on the last word; constant 0 when the parity feature is compiled out.

Function
REQ-016 shift_q shall be a register loaded each cycle with (rising_edge_found & rx_enable), giving a sampling latency of 1 cycle.
REQ-017 On a cycle with shift_q=1, sda_in as sampled that cycle shall shift into rx_data: shift left with LSB insert when MSB_FIRST=1, shift right with MSB insert when MSB_FIRST=0.
REQ-018 State machine states: IDLE (bit_count=0), SHIFT (data bits), PAR (parity bit, present only with the macro).
REQ-019 IDLE->SHIFT on the first shift_q=1; that bit is counted, so bit_count becomes 1.
REQ-020 In SHIFT, each shift_q=1 increments bit_count; the DATA_WIDTH-th data bit completes the frame (no parity) or moves to PAR (parity).
REQ-021 On frame completion, on the same edge: rx_word <= final shifted value; rx_valid <= 1; bit_count <= 0; state <= IDLE.
REQ-022 rx_valid shall clear on the edge where rx_ack=1; rx_ack while rx_valid=0 has no effect.
REQ-023 Completion with rx_valid=1 and no rx_ack that cycle: set overrun, overwrite rx_word, keep rx_valid=1.
REQ-024 Completion with rx_ack=1 on the same cycle: rx_valid stays 1 with the new word, and overrun is not set.
REQ-025 overrun shall clear only on rst or rx_clear.
REQ-026 rx_clear=1: state IDLE, bit_count=0, rx_data=0, overrun=0; takes priority over a simultaneous shift_q; rx_word, rx_valid and parity_err are unchanged.
REQ-027 Deasserting rx_enable mid-frame shall freeze the frame; it does not abort it.

Reset
REQ-028 rst=1 shall asynchronously force state IDLE and set shift_q, rx_data, rx_word, rx_valid, bit_count, overrun and parity_err to 0.
REQ-029 Reset asserted mid-frame shall discard the partial word, with no rx_valid pulse on reset release.

Configuration
REQ-030 Macro RX_SR_PARITY_EN; when defined, each frame is DATA_WIDTH data bits followed by one even-parity bit.
REQ-031 With the macro, the parity bit is not shifted into rx_data.
REQ-032 With the macro, on completion parity_err <= (XOR of data bits) != parity bit; parity_err is updated on every completion, and rx_word and rx_valid update regardless.
REQ-033 Without the macro: no PAR state; parity_err tied to 0; a frame is exactly DATA_WIDTH bits.

Verification
REQ-034 DATA_WIDTH=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 -> rx_word=8'hA5, rx_valid=1 two cycles after the last strobe, bit_count=0.
REQ-035 MSB_FIRST=0, same bit stream -> rx_word=8'hA5 bit-reversed = 8'hA5 (palindromic); repeat with 8'h01 stream -> rx_word=8'h80.
REQ-036 Two words 8'h3C then 8'hC3 with no rx_ack -> rx_word=8'hC3, overrun=1, rx_valid=1; rx_clear -> overrun=0.
REQ-037 rst pulsed after 4 of 8 bits, then 8 fresh bits 8'hFF -> rx_word=8'hFF, no spurious rx_valid.
REQ-038 RX_SR_PARITY_EN defined, data 8'h07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-039 rx_clear on the same cycle as the final shift_q -> no completion, bit_count=0, rx_valid unchanged.

Source files
------------

// File: rtl/rx_sr_param.sv
// Serial receive shift register: samples sda_in on qualified SCL rising edges and
// hands completed words to a consumer through a valid/ack pair with sticky overrun.
// Optional even-parity bit per frame is compiled in with macro RX_SR_PARITY_EN.
module rx_sr_param #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sda_in,
  input  logic                            rising_edge_found,
  input  logic                            rx_enable,
  input  logic                            rx_clear,
  output logic [DATA_WIDTH-1:0]           rx_data,
  output logic [DATA_WIDTH-1:0]           rx_word,
  output logic                            rx_valid,
  input  logic                            rx_ack,
  output logic [$clog2(DATA_WIDTH+2)-1:0] bit_count,
  output logic                            overrun,
  output logic                            parity_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH+2);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

  state_t                  state_q, state_d;
  logic                    shift_q;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0]   rx_word_q, rx_word_d;
  logic                    rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]        bit_count_q, bit_count_d;
  logic                    overrun_q, overrun_d;
  logic                    complete;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] cur,
                                                     input logic b);
    if (MSB_FIRST)
      return {cur[DATA_WIDTH-2:0], b};
    else
      return {b, cur[DATA_WIDTH-1:1]};
  endfunction

`ifdef RX_SR_PARITY_EN
  logic parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    rx_data_d   = rx_data_q;
    rx_word_d   = rx_word_q;
    rx_valid_d  = rx_valid_q;
    bit_count_d = bit_count_q;
    overrun_d   = overrun_q;
    complete    = 1'b0;
`ifdef RX_SR_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    if (rx_valid_q && rx_ack)
      rx_valid_d = 1'b0;

    // Abort beats a simultaneous sample; the delivered word is left alone.
    if (rx_clear) begin
      state_d     = IDLE;
      bit_count_d = '0;
      rx_data_d   = '0;
      overrun_d   = 1'b0;
    end else if (shift_q) begin
      case (state_q)
        IDLE, SHIFT: begin
          rx_data_d = shift_in(rx_data_q, sda_in);
          if (bit_count_q == CNT_W'(DATA_WIDTH-1)) begin
`ifdef RX_SR_PARITY_EN
            state_d     = PAR;
            bit_count_d = bit_count_q + CNT_W'(1);
`else
            complete  = 1'b1;
            rx_word_d = rx_data_d;
`endif
          end else begin
            state_d     = SHIFT;
            bit_count_d = bit_count_q + CNT_W'(1);
          end
        end
`ifdef RX_SR_PARITY_EN
        PAR: begin
          // Parity bit is checked but never enters the data register.
          complete     = 1'b1;
          rx_word_d    = rx_data_q;
          parity_err_d = (^rx_data_q) != sda_in;
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    if (complete) begin
      rx_valid_d  = 1'b1;
      bit_count_d = '0;
      state_d     = IDLE;
      if (rx_valid_q && !rx_ack)
        overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= 1'b0;
      rx_data_q   <= '0;
      rx_word_q   <= '0;
      rx_valid_q  <= 1'b0;
      bit_count_q <= '0;
      overrun_q   <= 1'b0;
`ifdef RX_SR_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= rising_edge_found & rx_enable;
      rx_data_q   <= rx_data_d;
      rx_word_q   <= rx_word_d;
      rx_valid_q  <= rx_valid_d;
      bit_count_q <= bit_count_d;
      overrun_q   <= overrun_d;
`ifdef RX_SR_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_word   = rx_word_q;
  assign rx_valid  = rx_valid_q;
  assign bit_count = bit_count_q;
  assign overrun   = overrun_q;
`ifdef RX_SR_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_sr_param.sv
// Directed bench for rx_sr_param: one MSB-first and one LSB-first instance share
// the same serial stimulus; parity cases are added when RX_SR_PARITY_EN is defined.
module tb_rx_sr_param;

`ifdef RX_SR_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sda_in = 1'b0;
  logic       rising_edge_found = 1'b0;
  logic       rx_enable = 1'b0;
  logic       rx_clear = 1'b0;
  logic       rx_ack = 1'b0;

  logic [7:0] m_data, m_word, l_data, l_word;
  logic       m_valid, l_valid, m_ovr, l_ovr, m_perr, l_perr;
  logic [3:0] m_cnt, l_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rx_sr_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sda_in(sda_in), .rising_edge_found(rising_edge_found),
    .rx_enable(rx_enable), .rx_clear(rx_clear), .rx_data(m_data), .rx_word(m_word),
    .rx_valid(m_valid), .rx_ack(rx_ack), .bit_count(m_cnt), .overrun(m_ovr),
    .parity_err(m_perr));

  rx_sr_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sda_in(sda_in), .rising_edge_found(rising_edge_found),
    .rx_enable(rx_enable), .rx_clear(rx_clear), .rx_data(l_data), .rx_word(l_word),
    .rx_valid(l_valid), .rx_ack(rx_ack), .bit_count(l_cnt), .overrun(l_ovr),
    .parity_err(l_perr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SCL strobe; returns at the negedge of the cycle in which shift_q is high.
  task automatic strobe(input logic b, input logic en);
    @(negedge clk);
    sda_in = b;
    rising_edge_found = 1'b1;
    rx_enable = en;
    @(negedge clk);
    rising_edge_found = 1'b0;
    rx_enable = 1'b1;
  endtask

  function automatic logic frame_bit(input logic [7:0] w, input int k);
    if (k < 8) return w[7-k];
    return ^w;
  endfunction

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int k = 0; k < n; k++) strobe(frame_bit(w, k), 1'b1);
  endtask

  task automatic ack_word;
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_data", m_data, 0);
    check("rst_word", m_word, 0);
    check("rst_valid", m_valid, 0);
    check("rst_cnt", m_cnt, 0);
    check("rst_ovr", m_ovr, 0);
    check("rst_perr", m_perr, 0);
    rst = 1'b0;
    rx_enable = 1'b1;

    // A5 on both bit orders
    send_bits(8'hA5, 3);
    @(negedge clk);
    check("cnt_mid", m_cnt, 3);
    send_bits(8'hA5 << 3, FRAME - 3);
    check("a5_latency_valid", m_valid, 0);
    check("a5_latency_cnt", m_cnt, FRAME - 1);
    @(negedge clk);
    check("a5_valid", m_valid, 1);
    check("a5_word_msb", m_word, 8'hA5);
    check("a5_word_lsb", l_word, 8'hA5);
    check("a5_cnt", m_cnt, 0);
    check("a5_data_msb", m_data, 8'hA5);
    check("a5_ovr", m_ovr, 0);
    check("a5_perr", m_perr, 0);
    ack_word;
    check("ack_valid", m_valid, 0);
    check("ack_word_held", m_word, 8'hA5);

    // 01 stream: MSB-first sees 01, LSB-first sees 80
    send_bits(8'h01, FRAME);
    @(negedge clk);
    check("01_word_msb", m_word, 8'h01);
    check("01_word_lsb", l_word, 8'h80);
    check("01_data_lsb", l_data, 8'h80);
    ack_word;

    // Overrun then rx_clear
    send_bits(8'h3C, FRAME);
    @(negedge clk);
    check("3c_word", m_word, 8'h3C);
    check("3c_ovr", m_ovr, 0);
    send_bits(8'hC3, FRAME);
    @(negedge clk);
    check("c3_word", m_word, 8'hC3);
    check("c3_ovr", m_ovr, 1);
    check("c3_valid", m_valid, 1);
    @(negedge clk); rx_clear = 1'b1;
    @(negedge clk); rx_clear = 1'b0;
    check("clr_ovr", m_ovr, 0);
    check("clr_valid_kept", m_valid, 1);
    check("clr_word_kept", m_word, 8'hC3);
    check("clr_data", m_data, 0);
    ack_word;
    check("ack2_valid", m_valid, 0);

    // Completion with ack on the same edge: no overrun, valid stays
    send_bits(8'h5A, FRAME);
    @(negedge clk);
    check("5a_valid", m_valid, 1);
    send_bits(8'h96, FRAME);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("ackcmp_valid", m_valid, 1);
    check("ackcmp_word", m_word, 8'h96);
    check("ackcmp_ovr", m_ovr, 0);
    ack_word;

    // rx_enable low freezes the frame
    send_bits(8'hF0, 4);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    @(negedge clk);
    check("freeze_cnt", m_cnt, 4);
    check("freeze_data", m_data[3:0], 4'hF);
    send_bits(8'h0F, 4);
`ifdef RX_SR_PARITY_EN
    strobe(1'b0, 1'b1);
`endif
    @(negedge clk);
    check("freeze_word", m_word, 8'hF0);
    check("freeze_valid", m_valid, 1);
    ack_word;

    // Reset mid-frame, then FF
    send_bits(8'h00, 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_cnt", m_cnt, 0);
    check("arst_word", m_word, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_novalid", m_valid, 0);
    send_bits(8'hFF, FRAME);
    check("ff_prevalid", m_valid, 0);
    @(negedge clk);
    check("ff_word", m_word, 8'hFF);
    check("ff_valid", m_valid, 1);

    // rx_clear on the final sample: no completion
    send_bits(8'h22, FRAME - 1);
    strobe(frame_bit(8'h22, FRAME - 1), 1'b1);
    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
    check("clrlast_cnt", m_cnt, 0);
    check("clrlast_valid", m_valid, 1);
    check("clrlast_word", m_word, 8'hFF);
    check("clrlast_data", m_data, 0);
    check("clrlast_ovr", m_ovr, 0);
    ack_word;

`ifdef RX_SR_PARITY_EN
    // Parity: 07 has odd data parity
    send_bits(8'h07, 8);
    strobe(1'b0, 1'b1);
    @(negedge clk);
    check("par0_perr", m_perr, 1);
    check("par0_word", m_word, 8'h07);
    check("par0_data", m_data, 8'h07);
    check("par0_perr_lsb", l_perr, 1);
    ack_word;
    send_bits(8'h07, 8);
    strobe(1'b1, 1'b1);
    @(negedge clk);
    check("par1_perr", m_perr, 0);
    check("par1_valid", m_valid, 1);
    ack_word;
`else
    check("noparity_perr", l_perr, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
